// File: rtl/mem_cmd_splitter_if.sv
// Command/status bundle for the memory command splitter.
// slave = splitter side, master = producer/datamover side.
interface mem_cmd_splitter_if;
  logic        s_cmd_valid;
  logic        s_cmd_ready;
  logic [63:0] s_cmd_address;
  logic [31:0] s_cmd_length;
  logic        m_cmd_valid;
  logic        m_cmd_ready;
  logic [63:0] m_cmd_address;
  logic [31:0] m_cmd_length;
  logic        s_sts_valid;
  logic        s_sts_ready;
  logic [7:0]  s_sts_data;
  logic        m_sts_valid;
  logic        m_sts_ready;
  logic [7:0]  m_sts_data;

  modport slave (
    input  s_cmd_valid, s_cmd_address, s_cmd_length,
    output s_cmd_ready,
    output m_cmd_valid, m_cmd_address, m_cmd_length,
    input  m_cmd_ready,
    input  s_sts_valid, s_sts_data,
    output s_sts_ready,
    output m_sts_valid, m_sts_data,
    input  m_sts_ready
  );

  modport master (
    output s_cmd_valid, s_cmd_address, s_cmd_length,
    input  s_cmd_ready,
    input  m_cmd_valid, m_cmd_address, m_cmd_length,
    output m_cmd_ready,
    output s_sts_valid, s_sts_data,
    input  s_sts_ready,
    input  m_sts_valid, m_sts_data,
    output m_sts_ready
  );
endinterface

// File: rtl/mem_cmd_splitter.sv
// Splits memory commands into boundary-safe chunks and folds the
// per-chunk statuses back into one status per original command.
module mem_cmd_splitter #(
  parameter int unsigned BOUNDARY   = 4096,
  parameter int unsigned MAX_CHUNK  = 4096,
  parameter int unsigned PEND_DEPTH = 16
) (
  input  logic              aclk,
  input  logic              areset,
  mem_cmd_splitter_if.slave bus
);

  localparam int unsigned BW = $clog2(BOUNDARY);
  localparam int unsigned PW = $clog2(PEND_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] cur_addr_q, cur_addr_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] cnt_q, cnt_d;
  logic [63:0] mc_addr_q, mc_addr_d;
  logic [31:0] mc_len_q, mc_len_d;
  logic        mc_valid_q, mc_valid_d;

  logic [31:0] pend_mem_q [PEND_DEPTH];
  logic [PW:0] wr_ptr_q, rd_ptr_q;
  logic        pend_full, pend_empty;
  logic        push, pop;
  logic [31:0] push_cnt;
  logic [31:0] head_cnt;

  logic        ok_q, ok_d;
  logic [2:0]  err_q, err_d;
  logic [3:0]  tag_q, tag_d;
  logic [31:0] rcv_q, rcv_d;
  logic        ms_valid_q, ms_valid_d;
  logic [7:0]  ms_data_q, ms_data_d;

  logic        cmd_rdy, sts_rdy;
  logic        cmd_acc, chunk_acc, sts_acc;
  logic        complete;
  logic [31:0] bnd_left, chunk;

  always_comb begin
    pend_empty = (wr_ptr_q == rd_ptr_q);
    pend_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    head_cnt   = pend_mem_q[rd_ptr_q[PW-1:0]];
    complete   = !pend_empty && (rcv_q == head_cnt);
    pop        = complete && !ms_valid_q;
    // ready lines are forced low for as long as reset is held
    cmd_rdy    = !areset && (state_q == IDLE) && !pend_full;
    sts_rdy    = !areset && !ms_valid_q && !complete;
    cmd_acc    = bus.s_cmd_valid && cmd_rdy;
    chunk_acc  = mc_valid_q && bus.m_cmd_ready;
    sts_acc    = bus.s_sts_valid && sts_rdy;
  end

  always_comb begin
    bnd_left = 32'(BOUNDARY) - 32'(cur_addr_q[BW-1:0]);
    chunk    = rem_q;
    if (chunk > 32'(MAX_CHUNK)) chunk = 32'(MAX_CHUNK);
    if (chunk > bnd_left)       chunk = bnd_left;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      mc_addr_q  <= '0;
      mc_len_q   <= '0;
      mc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      mc_addr_q  <= mc_addr_d;
      mc_len_q   <= mc_len_d;
      mc_valid_q <= mc_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_cnt   = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          if (bus.s_cmd_length == 32'd0) begin
            push = 1'b1;
          end else begin
            cur_addr_d = bus.s_cmd_address;
            rem_d      = bus.s_cmd_length;
            cnt_d      = '0;
            state_d    = CALC;
          end
        end
      end
      CALC: state_d = ISSUE;
      ISSUE: begin
        if (chunk_acc) begin
          cur_addr_d = cur_addr_q + 64'(mc_len_q);
          rem_d      = rem_q - mc_len_q;
          cnt_d      = cnt_q + 32'd1;
          if (rem_q == mc_len_q) begin
            push     = 1'b1;
            push_cnt = cnt_q + 32'd1;
            state_d  = IDLE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mc_addr_d  = mc_addr_q;
    mc_len_d   = mc_len_q;
    mc_valid_d = mc_valid_q;
    unique case (state_q)
      CALC: begin
        mc_addr_d  = cur_addr_q;
        mc_len_d   = chunk;
        mc_valid_d = 1'b1;
      end
      ISSUE: begin
        if (chunk_acc) mc_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // slot is reserved at accept time, so a push never meets a full FIFO
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(PEND_DEPTH); i++) begin
        pend_mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        pend_mem_q[wr_ptr_q[PW-1:0]] <= push_cnt;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    ok_d       = ok_q;
    err_d      = err_q;
    tag_d      = tag_q;
    rcv_d      = rcv_q;
    ms_valid_d = ms_valid_q;
    ms_data_d  = ms_data_q;
    if (pop) begin
      ms_data_d  = {ok_q, err_q, tag_q};
      ms_valid_d = 1'b1;
      ok_d       = 1'b1;
      err_d      = '0;
      tag_d      = '0;
      rcv_d      = '0;
    end else if (sts_acc) begin
      ok_d  = ok_q & bus.s_sts_data[7];
      err_d = err_q | bus.s_sts_data[6:4];
      tag_d = bus.s_sts_data[3:0];
      rcv_d = rcv_q + 32'd1;
    end
    if (ms_valid_q && bus.m_sts_ready) ms_valid_d = 1'b0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ok_q       <= 1'b1;
      err_q      <= '0;
      tag_q      <= '0;
      rcv_q      <= '0;
      ms_valid_q <= 1'b0;
      ms_data_q  <= '0;
    end else begin
      ok_q       <= ok_d;
      err_q      <= err_d;
      tag_q      <= tag_d;
      rcv_q      <= rcv_d;
      ms_valid_q <= ms_valid_d;
      ms_data_q  <= ms_data_d;
    end
  end

  assign bus.s_cmd_ready   = cmd_rdy;
  assign bus.m_cmd_valid   = mc_valid_q;
  assign bus.m_cmd_address = mc_addr_q;
  assign bus.m_cmd_length  = mc_len_q;
  assign bus.s_sts_ready   = sts_rdy;
  assign bus.m_sts_valid   = ms_valid_q;
  assign bus.m_sts_data    = ms_data_q;

endmodule

// File: tb/tb_mem_cmd_splitter.sv
// Randomized and directed bench for mem_cmd_splitter with a
// chunk-list / status-fold reference model.
module tb_mem_cmd_splitter;
  localparam int unsigned B    = 4096;
  localparam int unsigned MAXC = 4096;
  localparam int unsigned PD   = 16;
  localparam int          TMO  = 200;

  logic aclk = 1'b0;
  logic areset;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] exp_a[$];
  logic [31:0] exp_l[$];
  logic [63:0] got_a[$];
  logic [31:0] got_l[$];

  mem_cmd_splitter_if bus();

  mem_cmd_splitter #(
    .BOUNDARY(B), .MAX_CHUNK(MAXC), .PEND_DEPTH(PD)
  ) dut (
    .aclk(aclk), .areset(areset), .bus(bus)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // expected chunk list: greedy, never past MAXC or the next boundary
  task automatic model_split(input logic [63:0] a, input logic [31:0] l);
    logic [63:0] to_bnd;
    logic [31:0] c;
    exp_a.delete();
    exp_l.delete();
    while (l != 0) begin
      to_bnd = 64'(B) - (a % 64'(B));
      c = l;
      if (c > MAXC) c = MAXC;
      if (64'(c) > to_bnd) c = 32'(to_bnd);
      exp_a.push_back(a);
      exp_l.push_back(c);
      a = a + 64'(c);
      l = l - c;
    end
  endtask

  function automatic logic [7:0] model_agg(input logic [7:0] s[$]);
    bit         allok = 1'b1;
    logic [2:0] e = 3'b0;
    logic [3:0] t = 4'b0;
    foreach (s[i]) begin
      if (!s[i][7]) allok = 1'b0;
      e = e | s[i][6:4];
    end
    if (s.size() > 0) t = s[s.size()-1][3:0];
    return {allok, e, t};
  endfunction

  task automatic send_cmd(input logic [63:0] a, input logic [31:0] l,
                          output bit ok);
    ok = 1'b0;
    bus.s_cmd_valid   = 1'b1;
    bus.s_cmd_address = a;
    bus.s_cmd_length  = l;
    for (int i = 0; i < TMO && !ok; i++) begin
      if (bus.s_cmd_ready) ok = 1'b1;
      tick();
    end
    bus.s_cmd_valid = 1'b0;
  endtask

  task automatic get_chunk(output logic [63:0] a, output logic [31:0] l,
                           output bit ok);
    ok = 1'b0;
    a = '0;
    l = '0;
    bus.m_cmd_ready = 1'b1;
    for (int i = 0; i < TMO && !ok; i++) begin
      if (bus.m_cmd_valid) begin
        a  = bus.m_cmd_address;
        l  = bus.m_cmd_length;
        ok = 1'b1;
      end
      tick();
    end
    bus.m_cmd_ready = 1'b0;
  endtask

  task automatic send_sts(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    bus.s_sts_valid = 1'b1;
    bus.s_sts_data  = d;
    for (int i = 0; i < TMO && !ok; i++) begin
      if (bus.s_sts_ready) ok = 1'b1;
      tick();
    end
    bus.s_sts_valid = 1'b0;
  endtask

  task automatic get_sts(output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d = '0;
    bus.m_sts_ready = 1'b1;
    for (int i = 0; i < TMO && !ok; i++) begin
      if (bus.m_sts_valid) begin
        d  = bus.m_sts_data;
        ok = 1'b1;
      end
      tick();
    end
    bus.m_sts_ready = 1'b0;
  endtask

  // drives one command end to end, recording what the DUT produced
  task automatic run_cmd(input logic [63:0] a, input logic [31:0] l,
                         input logic [7:0] sq[$],
                         output bit ok, output logic [7:0] ms);
    logic [63:0] ca;
    logic [31:0] cl;
    bit          k;
    got_a.delete();
    got_l.delete();
    ok = 1'b1;
    send_cmd(a, l, k);
    ok &= k;
    foreach (sq[i]) begin
      get_chunk(ca, cl, k);
      ok &= k;
      if (k) begin
        got_a.push_back(ca);
        got_l.push_back(cl);
      end
      send_sts(sq[i], k);
      ok &= k;
    end
    get_sts(ms, k);
    ok &= k;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick();
    tick();
    total++;
    if ({bus.s_cmd_ready, bus.m_cmd_valid, bus.s_sts_ready,
         bus.m_sts_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_vr got=%b exp=0000", {bus.s_cmd_ready,
               bus.m_cmd_valid, bus.s_sts_ready, bus.m_sts_valid});
    end
    total++;
    if ({bus.m_cmd_address, bus.m_cmd_length, bus.m_sts_data} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", bus.m_cmd_address,
               bus.m_cmd_length, bus.m_sts_data);
    end
    areset = 1'b0;
    tick();
    total++;
    if ({bus.s_cmd_ready, bus.m_cmd_valid, bus.s_sts_ready,
         bus.m_sts_valid} !== 4'b1010) begin
      bad++;
      $display("FAIL post_reset got=%b exp=1010", {bus.s_cmd_ready,
               bus.m_cmd_valid, bus.s_sts_ready, bus.m_sts_valid});
    end
  endtask

  task automatic test_latency();
    bit          k;
    logic [63:0] ca;
    logic [31:0] cl;
    logic [7:0]  ms;
    send_cmd(64'h0, 32'h10, k);
    total++;
    if ({k, bus.m_cmd_valid} !== 2'b10) begin
      bad++;
      $display("FAIL lat_cycle1 got=%b exp=10", {k, bus.m_cmd_valid});
    end
    tick();
    total++;
    if (bus.m_cmd_valid !== 1'b1) begin
      bad++;
      $display("FAIL lat_cycle2 got=%b exp=1", bus.m_cmd_valid);
    end
    get_chunk(ca, cl, k);
    send_sts(8'h80, k);
    get_sts(ms, k);
    total++;
    if ({k, ms} !== 9'h180) begin
      bad++;
      $display("FAIL lat_sts got=%b/%h exp=1/80", k, ms);
    end
  endtask

  task automatic test_directed();
    logic [63:0] ta[5] = '{64'h0, 64'hFF0, 64'h10,
                           64'hFFFF_FFFF_FFFF_FF00, 64'h4000};
    logic [31:0] tl[5] = '{32'h3000, 32'h20, 32'h2000, 32'h200, 32'h3000};
    logic [7:0]  sq[$];
    logic [7:0]  ms;
    bit          k;
    for (int t = 0; t < 5; t++) begin
      model_split(ta[t], tl[t]);
      sq.delete();
      for (int i = 0; i < exp_a.size(); i++) begin
        if (t == 0) sq.push_back((i == 2) ? 8'h85 : 8'h80);
        else if (t == 4) sq.push_back((i == 1) ? 8'hA0 : 8'h80);
        else sq.push_back(8'h80 | 8'(i + 1));
      end
      run_cmd(ta[t], tl[t], sq, k, ms);
      total++;
      if (!k || got_a.size() != exp_a.size()) begin
        bad++;
        $display("FAIL dir%0d_count got=%0d/%b exp=%0d", t, got_a.size(),
                 k, exp_a.size());
      end
      for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
        total++;
        if ({got_a[i], got_l[i]} !== {exp_a[i], exp_l[i]}) begin
          bad++;
          $display("FAIL dir%0d_chunk%0d got=%h,%h exp=%h,%h", t, i,
                   got_a[i], got_l[i], exp_a[i], exp_l[i]);
        end
      end
      total++;
      if (ms !== model_agg(sq)) begin
        bad++;
        $display("FAIL dir%0d_sts got=%h exp=%h", t, ms, model_agg(sq));
      end
    end
  endtask

  task automatic test_zero_len();
    bit          k;
    logic [63:0] ca;
    logic [31:0] cl;
    logic [7:0]  ms;
    send_cmd(64'h1234, 32'h0, k);
    tick();
    tick();
    total++;
    if ({k, bus.m_cmd_valid, bus.m_sts_valid} !== 3'b101) begin
      bad++;
      $display("FAIL zero_nocmd got=%b exp=101",
               {k, bus.m_cmd_valid, bus.m_sts_valid});
    end
    send_cmd(64'h100, 32'h10, k);
    get_chunk(ca, cl, k);
    total++;
    if ({k, ca, cl} !== {1'b1, 64'h100, 32'h10}) begin
      bad++;
      $display("FAIL zero_chunk got=%b %h,%h exp=1 100,10", k, ca, cl);
    end
    get_sts(ms, k);
    total++;
    if ({k, ms} !== 9'h180) begin
      bad++;
      $display("FAIL zero_sts1 got=%b/%h exp=1/80", k, ms);
    end
    send_sts(8'h83, k);
    get_sts(ms, k);
    total++;
    if ({k, ms} !== 9'h183) begin
      bad++;
      $display("FAIL zero_sts2 got=%b/%h exp=1/83", k, ms);
    end
  endtask

  task automatic test_backpressure();
    bit          k;
    logic [63:0] a0;
    logic [31:0] l0;
    logic [7:0]  d0;
    send_cmd(64'h2FF8, 32'h40, k);
    tick();
    a0 = bus.m_cmd_address;
    l0 = bus.m_cmd_length;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({bus.m_cmd_valid, bus.m_cmd_address, bus.m_cmd_length} !==
          {1'b1, 64'h2FF8, 32'h8} || {a0, l0} !== {64'h2FF8, 32'h8}) begin
        bad++;
        $display("FAIL bp_cmd%0d got=%b %h,%h exp=1 2ff8,8", i,
                 bus.m_cmd_valid, bus.m_cmd_address, bus.m_cmd_length);
      end
    end
    get_chunk(a0, l0, k);
    send_sts(8'h81, k);
    get_chunk(a0, l0, k);
    send_sts(8'h92, k);
    tick();
    d0 = bus.m_sts_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({bus.m_sts_valid, bus.m_sts_data, bus.s_sts_ready} !==
          {1'b1, 8'h92, 1'b0} || d0 !== 8'h92) begin
        bad++;
        $display("FAIL bp_sts%0d got=%b %h %b exp=1 92 0", i,
                 bus.m_sts_valid, bus.m_sts_data, bus.s_sts_ready);
      end
    end
    get_sts(d0, k);
    total++;
    if ({bus.m_sts_valid, bus.s_sts_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_drop got=%b exp=01",
               {bus.m_sts_valid, bus.s_sts_ready});
    end
  endtask

  task automatic test_pend_full();
    bit          k;
    logic [63:0] ca;
    logic [31:0] cl;
    logic [7:0]  ms;
    for (int i = 0; i < int'(PD); i++) begin
      send_cmd(64'(i) * 64'h1000, 32'h10, k);
      get_chunk(ca, cl, k);
    end
    tick();
    total++;
    if (bus.s_cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready got=%b exp=0", bus.s_cmd_ready);
    end
    for (int i = 0; i < int'(PD); i++) begin
      send_sts(8'h80 | 8'(i), k);
      get_sts(ms, k);
      total++;
      if ({k, ms} !== {1'b1, 8'h80 | 8'(i)}) begin
        bad++;
        $display("FAIL full_drain%0d got=%b/%h exp=1/%h", i, k, ms,
                 8'h80 | 8'(i));
      end
      if (i == 0) begin
        total++;
        if (bus.s_cmd_ready !== 1'b1) begin
          bad++;
          $display("FAIL full_reopen got=%b exp=1", bus.s_cmd_ready);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit          k;
    logic [7:0]  sq[$];
    logic [7:0]  ms;
    send_cmd(64'h0, 32'h3000, k);
    tick();
    total++;
    if (bus.m_cmd_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre got=%b exp=1", bus.m_cmd_valid);
    end
    areset = 1'b1;
    #1;
    total++;
    if ({bus.s_cmd_ready, bus.m_cmd_valid, bus.s_sts_ready,
         bus.m_sts_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_mid got=%b exp=0000", {bus.s_cmd_ready,
               bus.m_cmd_valid, bus.s_sts_ready, bus.m_sts_valid});
    end
    tick();
    areset = 1'b0;
    tick();
    sq = '{8'h84};
    run_cmd(64'h100, 32'h10, sq, k, ms);
    total++;
    if ({k, got_a.size() == 1, ms} !== {2'b11, 8'h84} ||
        {got_a[0], got_l[0]} !== {64'h100, 32'h10}) begin
      bad++;
      $display("FAIL rst_after got=%b/%0d/%h exp=1/1/84", k,
               got_a.size(), ms);
    end
    tick();
    tick();
    total++;
    if ({bus.m_sts_valid, bus.m_cmd_valid} !== 2'b00) begin
      bad++;
      $display("FAIL rst_stale got=%b exp=00",
               {bus.m_sts_valid, bus.m_cmd_valid});
    end
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [31:0] l;
    logic [7:0]  sq[$];
    logic [7:0]  ms;
    bit          k;
    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'hFFF - 12'($urandom_range(0, 40));
      l = ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom_range(1, 12000));
      model_split(a, l);
      sq.delete();
      foreach (exp_a[i]) begin
        sq.push_back({$urandom_range(0, 5) != 0,
                      ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0,
                      4'($urandom)});
      end
      run_cmd(a, l, sq, k, ms);
      total++;
      if (!k || got_a.size() != exp_a.size() || got_l != exp_l ||
          got_a != exp_a) begin
        bad++;
        $display("FAIL rnd%0d_chunks a=%h l=%h got=%0d/%b exp=%0d", n, a,
                 l, got_a.size(), k, exp_a.size());
      end
      total++;
      if (ms !== model_agg(sq)) begin
        bad++;
        $display("FAIL rnd%0d_sts got=%h exp=%h", n, ms, model_agg(sq));
      end
    end
  endtask

  initial begin
    bus.s_cmd_valid   = 1'b0;
    bus.s_cmd_address = '0;
    bus.s_cmd_length  = '0;
    bus.m_cmd_ready   = 1'b0;
    bus.s_sts_valid   = 1'b0;
    bus.s_sts_data    = '0;
    bus.m_sts_ready   = 1'b0;
    test_reset();
    test_latency();
    test_directed();
    test_zero_len();
    test_backpressure();
    test_pend_full();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
